// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: FSM states,
// instruction classes, opcode/function codes, ALU operations and PC sources.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    // CLS_NONE doubles as the reset value and the "illegal opcode" marker.
    typedef enum logic [2:0] {
        CLS_NONE  = 3'd0,
        CLS_RTYPE = 3'd1,
        CLS_LW    = 3'd2,
        CLS_SW    = 3'd3,
        CLS_BEQ   = 3'd4,
        CLS_J     = 3'd5
    } iclass_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] PC_P4     = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_ENTRY  = 2'b11;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decode: opcode -> instruction class, and
// R-type function code -> ALU operation plus an illegal-function flag.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [5:0] opCode,
    input  logic [5:0] fnCode,
    output iclass_t    cls,
    output logic [2:0] rt_op,
    output logic       fn_illegal
);

    // Map the primary opcode onto an instruction class.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
        cls = CLS_NONE;
        case (opCode)
            OP_RTYPE: cls = CLS_RTYPE;
            OP_LW:    cls = CLS_LW;
            OP_SW:    cls = CLS_SW;
            OP_BEQ:   cls = CLS_BEQ;
            OP_J:     cls = CLS_J;
            default:  cls = CLS_NONE;
        endcase
    end

    // Map the R-type function code onto an ALU operation.
    always_comb begin
        rt_op      = ALU_ADD;
        fn_illegal = 1'b0;
        case (fnCode)
            FN_ADD:  rt_op = ALU_ADD;
            FN_SUB:  rt_op = ALU_SUB;
            FN_AND:  rt_op = ALU_AND;
            FN_OR:   rt_op = ALU_OR;
            FN_SLT:  rt_op = ALU_SLT;
            default: fn_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the MIPS-subset datapath. Walks each instruction
// through FETCH/DECODE/EXEC/MEM/WB, handshakes with a variable-latency memory,
// takes interrupts at instruction boundaries and traps on illegal codes or
// memory timeouts. All strobes are decoded from registered state and forced
// low while rst_n is asserted.
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opCode,
    input  logic [5:0] fnCode,
    input  logic       zero,
    input  logic       INT,
    input  logic       memReady,
    output logic       memReq,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       irWrite,
    output logic       PCWrite,
    output logic [1:0] PCSrc,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrc,
    output logic       Mem2Reg,
    output logic [2:0] op,
    output logic       intAck,
    output logic       fault,
    output logic [2:0] state
);

    localparam int unsigned       CW          = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [CW-1:0]     TIMEOUT_CNT = CW'(MEM_TIMEOUT);

    state_t        state_q, state_d;
    iclass_t       cls_q;
    logic [2:0]    op_q;
    logic          alusrc_q;
    logic [CW-1:0] wait_q, wait_d;

    iclass_t       dec_cls;
    logic [2:0]    rt_op;
    logic          fn_illegal;

    logic          req_c, iord_c, rd_c, wr_c, irw_c, pcw_c;
    logic [1:0]    pcsrc_c;
    logic          rdst_c, rw_c, asrc_c, m2r_c, ack_c, flt_c;
    logic [2:0]    op_c;
    logic          timeout;

    ctrl_decode u_decode (
        .opCode     (opCode),
        .fnCode     (fnCode),
        .cls        (dec_cls),
        .rt_op      (rt_op),
        .fn_illegal (fn_illegal)
    );

    // The wait counter only advances while a request is outstanding, so
    // reaching the limit always means the current request went unanswered.
    // The timeout wins over a memReady arriving in the same cycle.
    assign timeout = (wait_q == TIMEOUT_CNT);

    // Next-state and strobe decode from registered state and latched class.
    always_comb begin
        state_d = state_q;
        req_c   = 1'b0;
        iord_c  = 1'b0;
        rd_c    = 1'b0;
        wr_c    = 1'b0;
        irw_c   = 1'b0;
        pcw_c   = 1'b0;
        pcsrc_c = PC_P4;
        rdst_c  = 1'b0;
        rw_c    = 1'b0;
        asrc_c  = 1'b0;
        m2r_c   = 1'b0;
        op_c    = ALU_AND;
        ack_c   = 1'b0;
        flt_c   = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (wait_q == '0 && INT) begin
                    pcw_c   = 1'b1;
                    pcsrc_c = PC_ENTRY;
                    ack_c   = 1'b1;
                end else begin
                    req_c = 1'b1;
                    rd_c  = 1'b1;
                    if (timeout) begin
                        state_d = S_FAULT;
                    end else if (memReady) begin
                        irw_c   = 1'b1;
                        pcw_c   = 1'b1;
                        pcsrc_c = PC_P4;
                        state_d = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                case (dec_cls)
                    CLS_NONE: state_d = S_FAULT;
                    CLS_J: begin
                        pcw_c   = 1'b1;
                        pcsrc_c = PC_JUMP;
                        state_d = S_FETCH;
                    end
                    default:  state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (cls_q)
                    CLS_RTYPE: begin
                        op_c    = rt_op;
                        state_d = fn_illegal ? S_FAULT : S_WB;
                    end
                    CLS_LW, CLS_SW: begin
                        op_c    = ALU_ADD;
                        asrc_c  = 1'b1;
                        state_d = S_MEM;
                    end
                    CLS_BEQ: begin
                        op_c    = ALU_SUB;
                        if (zero) begin
                            pcw_c   = 1'b1;
                            pcsrc_c = PC_BRANCH;
                        end
                        state_d = S_FETCH;
                    end
                    default:   state_d = S_FAULT;
                endcase
            end
            S_MEM: begin
                req_c  = 1'b1;
                iord_c = 1'b1;
                rd_c   = (cls_q == CLS_LW);
                wr_c   = (cls_q == CLS_SW);
                op_c   = op_q;
                asrc_c = alusrc_q;
                if (timeout) begin
                    state_d = S_FAULT;
                end else if (memReady) begin
                    state_d = (cls_q == CLS_LW) ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                rw_c    = 1'b1;
                rdst_c  = (cls_q == CLS_RTYPE);
                m2r_c   = (cls_q == CLS_LW);
                op_c    = op_q;
                asrc_c  = alusrc_q;
                state_d = S_FETCH;
            end
            S_FAULT: begin
                flt_c = 1'b1;
                if (INT) begin
                    pcw_c   = 1'b1;
                    pcsrc_c = PC_ENTRY;
                    ack_c   = 1'b1;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Wait counter: restarts on every state change and on each completed
    // access, counts cycles with an outstanding request otherwise.
    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (req_c && memReady) begin
            wait_d = '0;
        end else if (req_c) begin
            wait_d = wait_q + CW'(1);
        end
    end

    // State, class, held ALU controls and wait counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            cls_q    <= CLS_NONE;
            op_q     <= ALU_AND;
            alusrc_q <= 1'b0;
            wait_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            wait_q  <= wait_d;
            if (state_q == S_DECODE) begin
                cls_q <= dec_cls;
            end
            if (state_q == S_EXEC) begin
                op_q     <= op_c;
                alusrc_q <= asrc_c;
            end
        end
    end

    // NOTE: strobes are gated by rst_n directly so a reset mid-access kills a write in the same cycle, not at the next edge.
    assign memReq   = rst_n & req_c;
    assign IorD     = rst_n & iord_c;
    assign MemRead  = rst_n & rd_c;
    assign MemWrite = rst_n & wr_c;
    assign irWrite  = rst_n & irw_c;
    assign PCWrite  = rst_n & pcw_c;
    assign PCSrc    = rst_n ? pcsrc_c : PC_P4;
    assign RegDst   = rst_n & rdst_c;
    assign RegWrite = rst_n & rw_c;
    assign ALUSrc   = rst_n & asrc_c;
    assign Mem2Reg  = rst_n & m2r_c;
    assign op       = rst_n ? op_c : ALU_AND;
    assign intAck   = rst_n & ack_c;
    assign fault    = rst_n & flt_c;
    assign state    = state_q;

endmodule
